// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encodings, register-index
// width, default stall-counter width and the control-word bundle.
package pipeline_ctrl_pkg;

    localparam int REG_IDX_W       = 5;
    localparam int STALL_CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_ERR  = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic en_a;
        logic en_b;
        logic en_c;
        logic en_d;
        logic flush_a;
        logic flush_b;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, en_a: 1'b1, en_b: 1'b1, en_c: 1'b1,
                                   en_d: 1'b1, flush_a: 1'b0, flush_b: 1'b0};
    // A full freeze and the reset word are the same all-zero control word.
    localparam ctrl_t CTRL_FREEZE = '0;

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// Load-use hazard detector: a load in EX whose destination feeds the
// instruction in ID. Register 0 never creates a dependency.
module hazard_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic                 mem_read,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    output logic                 load_use
);

    assign load_use = mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with memory-wait FSM and stall-cycle counter.
// Optional memory-timeout abort is enabled by defining MEM_TIMEOUT_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   idExMemRead,
    input  logic [REG_IDX_W-1:0]   idExRt,
    input  logic [REG_IDX_W-1:0]   ifIdRs,
    input  logic [REG_IDX_W-1:0]   ifIdRt,
    input  logic                   branchTaken,
    input  logic                   memReq,
    input  logic                   memReady,
    output logic                   pcWrite,
    output logic                   enA,
    output logic                   enB,
    output logic                   enC,
    output logic                   enD,
    output logic                   flushA,
    output logic                   flushB,
    output logic [STALL_CNT_W-1:0] stallCycles,
    output logic                   memError,
    output logic [1:0]             state
);

    state_t                 cur_state;
    ctrl_t                  ctrl;
    logic                   load_use;
    logic                   timeout;
    logic [STALL_CNT_W-1:0] stall_cnt;

    hazard_unit u_hazard (
        .mem_read (idExMemRead),
        .ex_rt    (idExRt),
        .id_rs    (ifIdRs),
        .id_rt    (ifIdRt),
        .load_use (load_use)
    );

    // NOTE: default the whole control word first so every path assigns it and no latch is inferred.
    always_comb begin
        ctrl = CTRL_RUN;
        if (rst) begin
            ctrl = CTRL_FREEZE;
        end else begin
            case (cur_state)
                ST_RUN: begin
                    if (memReq && !memReady) begin
                        ctrl = CTRL_FREEZE;
                    end else if (branchTaken) begin
                        ctrl.flush_a = 1'b1;
                        ctrl.flush_b = 1'b1;
                    end else if (load_use) begin
                        ctrl.pc_write = 1'b0;
                        ctrl.en_a     = 1'b0;
                        ctrl.flush_b  = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!memReady) ctrl = CTRL_FREEZE;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
    logic [TO_W-1:0] wait_cnt;

    // Held at zero outside MEM_WAIT, so every entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || cur_state != ST_MEM_WAIT) wait_cnt <= '0;
        else                                 wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout  = (cur_state == ST_MEM_WAIT) && (wait_cnt == TO_W'(MEM_TIMEOUT - 1));
    assign memError = !rst && (cur_state == ST_MEM_ERR);
`else
    logic unused_mem_timeout;
    assign unused_mem_timeout = (MEM_TIMEOUT != 0);
    assign timeout            = 1'b0;
    assign memError           = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            if (!ctrl.pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            case (cur_state)
                ST_RUN:      if (memReq && !memReady) cur_state <= ST_MEM_WAIT;
                ST_MEM_WAIT: begin
                    if (memReady)     cur_state <= ST_RUN;
                    else if (timeout) cur_state <= ST_MEM_ERR;
                end
                default:     cur_state <= ST_RUN;
            endcase
        end
    end

    assign pcWrite     = ctrl.pc_write;
    assign enA         = ctrl.en_a;
    assign enB         = ctrl.en_b;
    assign enC         = ctrl.en_c;
    assign enD         = ctrl.en_d;
    assign flushA      = ctrl.flush_a;
    assign flushB      = ctrl.flush_b;
    assign stallCycles = stall_cnt;
    assign state       = cur_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard/memory/reset scenarios
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int STALL_CNT_W = 6;
    localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

    // Control words as {pcWrite, enA, enB, enC, enD, flushA, flushB}.
    localparam logic [6:0] W_DEFAULT = 7'b1111100;
    localparam logic [6:0] W_FREEZE  = 7'b0000000;
    localparam logic [6:0] W_BUBBLE  = 7'b0011101;
    localparam logic [6:0] W_FLUSH   = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, idExMemRead, branchTaken, memReq, memReady;
    logic [4:0]             idExRt, ifIdRs, ifIdRt;
    logic                   pcWrite, enA, enB, enC, enD, flushA, flushB, memError;
    logic [STALL_CNT_W-1:0] stallCycles;
    logic [1:0]             state;
    logic [6:0]             dut_ctrl;

    assign dut_ctrl = {pcWrite, enA, enB, enC, enD, flushA, flushB};

    pipeline_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .STALL_CNT_W(STALL_CNT_W)) dut (
        .clk(clk), .rst(rst), .idExMemRead(idExMemRead), .idExRt(idExRt),
        .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .branchTaken(branchTaken),
        .memReq(memReq), .memReady(memReady), .pcWrite(pcWrite), .enA(enA),
        .enB(enB), .enC(enC), .enD(enD), .flushA(flushA), .flushB(flushB),
        .stallCycles(stallCycles), .memError(memError), .state(state)
    );

    int checks   = 0;
    int failures = 0;

    // Model: 0 = running, 1 = waiting on memory, 2 = error pulse.
    int m_mode  = 0;
    int m_wait  = 0;
    int m_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_ctrl();
        bit lu;
        lu = idExMemRead && idExRt != 0 && (idExRt == ifIdRs || idExRt == ifIdRt);
        if (rst) return W_FREEZE;
        if (m_mode == 0) begin
            if (memReq && !memReady) return W_FREEZE;
            if (branchTaken)         return W_FLUSH;
            if (lu)                  return W_BUBBLE;
            return W_DEFAULT;
        end
        if (m_mode == 1) return memReady ? W_DEFAULT : W_FREEZE;
        return W_DEFAULT;
    endfunction

    task automatic model_advance(input logic pc);
        if (rst) begin
            m_mode = 0; m_wait = 0; m_stall = 0;
        end else begin
            if (!pc && m_stall < STALL_MAX) m_stall++;
            if (m_mode == 0) begin
                if (memReq && !memReady) begin m_mode = 1; m_wait = 0; end
            end else if (m_mode == 1) begin
                if (memReady) m_mode = 0;
                else begin
                    m_wait++;
`ifdef MEM_TIMEOUT_EN
                    if (m_wait == MEM_TIMEOUT) m_mode = 2;
`endif
                end
            end else begin
                m_mode = 0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic [4:0] rt,
                         input logic [4:0] rs, input logic [4:0] rt2,
                         input logic br, input logic req, input logic rdy);
        rst = r; idExMemRead = ld; idExRt = rt; ifIdRs = rs; ifIdRt = rt2;
        branchTaken = br; memReq = req; memReady = rdy;
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Compare everything against the model, then clock one cycle.
    task automatic tick();
        logic [6:0] e;
        e = model_ctrl();
        check("ctrl", dut_ctrl, e);
        check("memError", memError, (!rst && m_mode == 2));
        check("state", state, m_mode);
        check("stallCycles", stallCycles, m_stall);
        model_advance(e[6]);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rst_ctrl", dut_ctrl, W_FREEZE);
        tick();
        tick();
        idle();
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_state", state, 0);
        check("reset_stall", stallCycles, 0);
        do_reset();

        // Load-use on rs
        drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0);
        check("loaduse_ctrl", dut_ctrl, W_BUBBLE);
        tick();
        idle();
        check("loaduse_stall", stallCycles, 1);
        check("loaduse_release", dut_ctrl, W_DEFAULT);
        tick();

        // Destination register 0 never stalls
        drive(1'b0, 1'b1, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        check("r0_ctrl", dut_ctrl, W_DEFAULT);
        tick();

        // Branch wins over load-use
        drive(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        check("branch_ctrl", dut_ctrl, W_FLUSH);
        tick();
        idle();
        check("branch_stall", stallCycles, 1);

        // Memory hit completes with no stall
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("memhit_ctrl", dut_ctrl, W_DEFAULT);
        tick();

        // Memory stall: three frozen cycles, release on the fourth
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("memst_s0", state, 0);
        check("memst_c0", dut_ctrl, W_FREEZE);
        tick();
        check("memst_s1", state, 1);
        tick();
        check("memst_s2", state, 1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check("memst_s3", state, 1);
        check("memst_rel", dut_ctrl, W_DEFAULT);
        tick();
        idle();
        check("memst_s4", state, 0);
        check("memst_stall", stallCycles, 4);
        tick();

        // Memory never ready
        do_reset();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (5) tick();
`ifdef MEM_TIMEOUT_EN
        check("timeout_state", state, 2);
        check("timeout_err", memError, 1);
        check("timeout_ctrl", dut_ctrl, W_DEFAULT);
        tick();
        check("timeout_after", state, 0);
`else
        check("noto_state", state, 1);
        check("noto_err", memError, 0);
        tick();
        check("noto_after", state, 1);
`endif
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();

        // Reset in the second MEM_WAIT cycle
        do_reset();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("rstwait_ctrl", dut_ctrl, W_FREEZE);
        check("rstwait_err", memError, 0);
        tick();
        idle();
        check("rstwait_state", state, 0);
        check("rstwait_stall", stallCycles, 0);
        tick();

        // Counter saturation
        do_reset();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (80) tick();
        check("stall_sat", stallCycles, STALL_MAX);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
